// File: rtl/piso_shift_reg_pkg.sv
// Shared types and constants for the parallel-in serial-out shifter.
package piso_shift_reg_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } piso_state_e;

   localparam bit MSB_FIRST_MODE = 1'b1;
   localparam bit LSB_FIRST_MODE = 1'b0;

   // Enough bits to hold 0..dw.
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Beat counter: counts 0..DATAWIDTH-1 and wraps; tc_o flags the final beat.
module piso_bit_counter
   import piso_shift_reg_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int CW        = cnt_width(DATAWIDTH)
) (
   input  logic Clk,
   input  logic Rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with valid/ready on both sides and
// gapless reload on the final beat of a word.
module piso_shift_reg
   import piso_shift_reg_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] d,
   input  logic                 load_valid,
   output logic                 load_ready,
   output logic                 sout,
   output logic                 sout_valid,
   input  logic                 sout_ready,
   output logic                 done
);

   piso_state_e          state_q, state_d;
   logic [DATAWIDTH-1:0] shreg_q, shreg_d;
   logic [DATAWIDTH-1:0] shifted;
   logic                 tc, beat, accept;

   piso_bit_counter #(.DATAWIDTH(DATAWIDTH)) u_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .en_i  (beat),
      .clr_i (accept),
      .tc_o  (tc)
   );

   assign sout_valid = (state_q == S_SHIFT);
   assign beat       = sout_valid && sout_ready;
   assign done       = beat && tc;
   assign load_ready = (state_q == S_IDLE) || (sout_valid && tc && sout_ready);
   assign accept     = load_valid && load_ready;

   // Zero fill means the register is empty again once a word drains, so sout
   // needs no separate gating in S_IDLE.
   assign sout    = (MSB_FIRST == MSB_FIRST_MODE) ? shreg_q[DATAWIDTH-1] : shreg_q[0];
   assign shifted = (MSB_FIRST == MSB_FIRST_MODE) ? (shreg_q << 1) : (shreg_q >> 1);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      if (accept) begin
         state_d = S_SHIFT;
         shreg_d = d;
      end else if (beat) begin
         shreg_d = shifted;
         if (tc)
            state_d = S_IDLE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register: drains a stored DATAWIDTH-bit word one bit per accepted beat.
- Serves as the read/transmit end of the datapath storage elements, turning parallel register contents into a bit stream for serial consumers.
- Valid/ready handshakes on both the load side and the serial side.
- Supports gapless back-to-back words.

Parameters:
DATAWIDTH, 8, word width in bits (legal range 1 to 64)
MSB_FIRST, 1, 1 = shift out bit DATAWIDTH-1 first; 0 = shift out bit 0 first

Ports:
Clk  input  1  clock; all logic on rising edge
Rst  input  1  synchronous active-high reset
d  input  DATAWIDTH  parallel word to load
load_valid  input  1  upstream offers d
load_ready  output  1  block can accept d this cycle
sout  output  1  current serial bit
sout_valid  output  1  sout holds a valid bit
sout_ready  input  1  downstream consumes sout this cycle
done  output  1  one-cycle pulse on the cycle the last bit of a word is consumed

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-high (Rst). Rst is sampled only on the Clk rising edge.
- Reset state: S_IDLE, shift register = 0, bit counter = 0.
- Output reset values: sout=0, sout_valid=0, done=0, load_ready=1.
- State machine has two states:
  - S_IDLE: sout_valid=0, load_ready=1.
  - S_SHIFT: sout_valid=1.
- Load:
  - A load is accepted when load_valid && load_ready at the clock edge.
  - Accepted d is captured and the block enters S_SHIFT.
  - The first bit appears on sout the cycle after acceptance (latency 1).
- Beat: a beat occurs when sout_valid && sout_ready.
  - On a beat, the shift register advances one position toward the output end and the counter increments.
  - Without sout_ready, sout, counter and the shift register hold (stall).
- sout mapping:
  - MSB_FIRST=1: sout = shreg[DATAWIDTH-1], shift left, zero fill.
  - MSB_FIRST=0: sout = shreg[0], shift right, zero fill.
- Counter:
  - Width $clog2(DATAWIDTH+1).
  - Counts beats 0..DATAWIDTH-1 and resets to 0 at the end of each word.
- Last beat (counter == DATAWIDTH-1 and beat):
  - done=1 combinationally that cycle.
  - If load_valid is also high, the new word is captured and the block stays in S_SHIFT with no bubble.
  - Otherwise the block returns to S_IDLE.
- load_ready = S_IDLE || (S_SHIFT && counter==DATAWIDTH-1 && sout_ready). Combinational, with no dependence on load_valid.
- load_valid while busy and not on the last beat: ignored, d not sampled, no error flag.
- DATAWIDTH=1: every beat is a last beat; each word lasts exactly one beat; done fires on each beat.
- Reset mid-word: the word is discarded and all outputs return to reset values after the edge. Rst has priority over load and beat.
- done is never asserted in S_IDLE.
- done is never asserted twice for one word.

Decomposition:
- Shared package holds:
  - state enum (S_IDLE, S_SHIFT)
  - counter-width localparam helper via $clog2
  - MSB_FIRST encoding constants
- One sub-module is natural: piso_bit_counter (enable, clear, terminal-count output at DATAWIDTH-1), with Clk/Rst as above.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset then idle, parameters default (DATAWIDTH=8, MSB_FIRST=1) -> load_ready=1, sout_valid=0, sout=0, done=0 for 5 cycles.
- Load 0xA5 (default parameters), sout_ready=1 -> sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after acceptance; done high on cycle 8 only; then S_IDLE.
- MSB_FIRST=0, load 0xA5 -> sout 1,0,1,0,0,1,0,1 (LSB first). Load 0x01 -> 1,0,0,0,0,0,0,0.
- Back-to-back: load 0xF0 and hold load_valid with 0x0F ready on the last beat -> 16 contiguous valid beats 11110000 00001111; load_ready high only on beat 8; two done pulses.
- Stall: load 0x81, drop sout_ready for 3 cycles after beat 2 -> sout/sout_valid held during the stall; load_valid pulses during the stall ignored; sequence resumes and completes correctly.
- Rst asserted at beat 4 of 0xFF -> next cycle sout_valid=0, load_ready=1; a fresh load of 0x3C then serializes fully and correctly.
